// File: rtl/aes_enc_sequencer.sv
// rtl/aes_enc_sequencer.sv - sequences key expansion and block encipherment around an external AES core
//
// Purpose:
//   Accepts plaintext blocks on an upstream valid/ready handshake, drives an
//   external encipher core through a start/ready protocol, and returns results
//   on a downstream valid/ready handshake. A key-expansion request kicks an
//   external key memory and gates block acceptance until the key is valid.
//
// Configuration:
//   AES_CTR_MODE_EN  defined   -> counter mode: the core enciphers a 128-bit
//                                 counter and the result is XORed with the
//                                 captured plaintext.
//                    undefined -> ECB: the core enciphers the plaintext directly;
//                                 ctr_load/ctr_iv are ignored.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   key_init_req / key_init          key expansion request in, one-cycle pulse out
//   key_ready                        key memory done/idle flag
//   in_valid/in_ready/in_block       upstream plaintext handshake
//   out_valid/out_ready/out_block    downstream result handshake
//   core_next/core_block             start pulse and block to the encipher core
//   core_ready/core_result           encipher core ready flag and result
//   ctr_load/ctr_iv                  counter preload (counter mode only)
//   busy                             high in every state except IDLE
//   blk_cnt                          count of delivered blocks, wraps at 2^CNT_W

module aes_enc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_init_req,
  output logic             key_init,
  input  logic             key_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic             core_next,
  output logic [127:0]     core_block,
  input  logic             core_ready,
  input  logic [127:0]     core_result,
  input  logic             ctr_load,
  input  logic [127:0]     ctr_iv,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_START,
    KEY_WAIT,
    CORE_START,
    CORE_WAIT_LO,
    CORE_WAIT_HI,
    OUTPUT
  } state_t;

  state_t state;
  logic   key_valid;
  // Blocks the first KEY_WAIT cycle so a stale key_ready from before the
  // key_init pulse cannot end the wait early.
  logic   key_wait_first;

`ifdef AES_CTR_MODE_EN
  logic [127:0] data_q;
  logic [127:0] counter;
`else
  logic unused_ctr;
  assign unused_ctr = ^{ctr_load, ctr_iv};
`endif

  // A pending key request takes priority over a block, so never offer ready then.
  assign in_ready = (state == IDLE) && key_valid && !key_init_req;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      key_valid      <= 1'b0;
      key_wait_first <= 1'b0;
      key_init       <= 1'b0;
      core_next      <= 1'b0;
      out_valid      <= 1'b0;
      core_block     <= '0;
      out_block      <= '0;
      blk_cnt        <= '0;
`ifdef AES_CTR_MODE_EN
      data_q         <= '0;
      counter        <= '0;
`endif
    end else begin
      key_init  <= 1'b0;
      core_next <= 1'b0;
      case (state)
        IDLE: begin
`ifdef AES_CTR_MODE_EN
          if (ctr_load) counter <= ctr_iv;
`endif
          if (key_init_req) begin
            key_init <= 1'b1;
            state    <= KEY_START;
          end else if (in_valid && key_valid) begin
            core_next <= 1'b1;
`ifdef AES_CTR_MODE_EN
            data_q     <= in_block;
            core_block <= counter;
`else
            core_block <= in_block;
`endif
            state <= CORE_START;
          end
        end
        KEY_START: begin
          key_valid      <= 1'b0;
          key_wait_first <= 1'b1;
          state          <= KEY_WAIT;
        end
        KEY_WAIT: begin
          if (key_wait_first) begin
            key_wait_first <= 1'b0;
          end else if (key_ready) begin
            key_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        CORE_START: state <= CORE_WAIT_LO;
        CORE_WAIT_LO: begin
          if (!core_ready) state <= CORE_WAIT_HI;
        end
        CORE_WAIT_HI: begin
          if (core_ready) begin
`ifdef AES_CTR_MODE_EN
            out_block <= core_result ^ data_q;
`else
            out_block <= core_result;
`endif
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            blk_cnt   <= blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef AES_CTR_MODE_EN
            counter   <= counter + 128'd1;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_enc_sequencer.md
AES_ENC_SEQUENCER -- requirements
Module: aes_enc_sequencer

Interface
REQ-001 Parameter: CNT_W, default 16, width of the completed-block counter.
REQ-002 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port reset  in  1  synchronous, active-high reset.
REQ-004 Port key_init_req  in  1  request for key expansion; pulse, sampled only in IDLE.
REQ-005 Port key_init  out  1  one-cycle pulse to the key memory.
REQ-006 Port key_ready  in  1  key memory done/idle flag.
REQ-007 Ports in_valid/in_ready/in_block  in/out/in  1/1/128  upstream plaintext handshake.
REQ-008 Ports out_valid/out_ready/out_block  out/in/out  1/1/128  downstream result handshake.
REQ-009 Port core_next  out  1  one-cycle start pulse to the encipher block.
REQ-010 Port core_block  out  128  registered block presented to the encipher block.
REQ-011 Ports core_ready/core_result  in/in  1/128  encipher ready flag and result.
REQ-012 Ports ctr_load/ctr_iv  in/in  1/128  counter preload; used only with AES_CTR_MODE_EN.
REQ-013 Ports busy/blk_cnt  out/out  1/CNT_W  not-IDLE flag; count of blocks delivered.

Function
REQ-014 FSM states: IDLE, KEY_START, KEY_WAIT, CORE_START, CORE_WAIT_LO, CORE_WAIT_HI, OUTPUT.
REQ-015 IDLE: key_init_req=1 -> KEY_START; else in_valid=1 and key_valid=1 -> CORE_START; key_init_req wins on a tie.
REQ-016 In_ready is 1 only in IDLE with key_valid=1 and key_init_req=0; the transfer captures in_block into an internal data register and loads core_block.
REQ-017 KEY_START: key_init=1 for exactly one cycle, clear key_valid, go to KEY_WAIT.
REQ-018 KEY_WAIT: wait one cycle minimum, then on key_ready=1 set key_valid=1 and go to IDLE.
REQ-019 CORE_START: core_next=1 for exactly one cycle, go to CORE_WAIT_LO.
REQ-020 CORE_WAIT_LO: stay until core_ready=0, then go to CORE_WAIT_HI.
REQ-021 CORE_WAIT_HI: on core_ready=1, register out_block, go to OUTPUT.
REQ-022 OUTPUT: out_valid=1; out_block is held stable while out_ready=0; on out_ready=1, increment blk_cnt and go to IDLE.
REQ-023 Blk_cnt wraps modulo 2^CNT_W.
REQ-024 Minimum latency from the in_valid/in_ready transfer to out_valid is 4 cycles plus the encipher duration.
REQ-025 Key_init_req outside IDLE is ignored and is not queued.
REQ-026 Busy=1 in every state except IDLE.

Reset
REQ-027 Reset=1 at a clock edge forces IDLE from any state, including mid-encipher or mid-key-expansion.
REQ-028 Reset values: key_valid=0, blk_cnt=0, out_valid=0, in_ready=0, core_next=0, key_init=0, busy=0, core_block=0, out_block=0, counter=0.

Configuration
REQ-029 Macro AES_CTR_MODE_EN defined: a 128-bit counter register is present.
REQ-030 With AES_CTR_MODE_EN: ctr_load=1 in IDLE loads ctr_iv into the counter.
REQ-031 With AES_CTR_MODE_EN: on an input transfer, core_block = counter.
REQ-032 With AES_CTR_MODE_EN: out_block = core_result XOR captured in_block.
REQ-033 With AES_CTR_MODE_EN: the counter increments by 1 modulo 2^128 on each out handshake.
REQ-034 Macro AES_CTR_MODE_EN undefined (ECB): core_block = in_block, out_block = core_result, and ctr_load/ctr_iv are ignored.

Verification
REQ-035 Reset then in_valid=1 without a key -> in_ready stays 0 and core_next never pulses.
REQ-036 key_init_req pulse, key_ready low 5 cycles then high -> one key_init pulse, then key_valid=1; ECB FIPS-197 key 000102..0f, block 00112233..ff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 out_ready held 0 for 10 cycles in OUTPUT -> out_block stable, in_ready=0, blk_cnt unchanged until the handshake.
REQ-038 blk_cnt preset near wrap (CNT_W=4, 17 blocks) -> blk_cnt reads 1.
REQ-039 Reset asserted in CORE_WAIT_HI -> next cycle IDLE, key_valid=0, out_valid=0.
REQ-040 AES_CTR_MODE_EN, ctr_iv=ff..ff, two blocks -> core_block values ff..ff then 00..00, and out_block = E(ctr) XOR in_block.
